// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// (e.g. 0xED set-LEDs, 0xFF reset) over the same ps2_clk/ps2_data pins used by
// the keyboard receive path. The pins are driven open-drain through the *_oe
// outputs: 1 pulls the line low, 0 releases it. While busy is high the
// neighbouring receiver must ignore the line.
//
// Transfer sequence:
//   IDLE -> INHIBIT (clock held low, then data pulled low for one cycle)
//        -> REQ (clock released, start bit on data)
//        -> DATA (bits 0..7, odd parity, stop, one per device falling edge)
//        -> ACK (sample device ack on edge 11)
//        -> WAIT_IDLE (both lines high) -> tx_done
//   A timeout counter runs from REQ through ACK and aborts the transfer.
//
// Parameters:
//   INHIBIT_CYCLES  clock-low inhibit time in clk cycles
//   TIMEOUT_CYCLES  max cycles from entering REQ to ack sampled
//
// Optional feature (compile-time macro PS2_TX_RETRY_EN):
//   defined   - on the first error the same byte is re-sent once; tx_done and
//               tx_error are reported only after the final attempt.
//   undefined - every error ends the transfer immediately.
//
// Ports:
//   clk          in   clock (fast_clk domain)
//   reset        in   synchronous, active-high reset
//   tx_data      in   byte to send
//   tx_valid     in   request; byte accepted when tx_valid && tx_ready
//   tx_ready     out  high only in IDLE (and not in the tx_done cycle)
//   ps2_clk_in   in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  in   raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   out  1 = pull PS/2 clock low
//   ps2_data_oe  out  1 = pull PS/2 data low
//   busy         out  high in every state except IDLE
//   tx_done      out  one-cycle pulse at end of transfer
//   tx_error     out  valid with tx_done: 1 = timeout or missing ack
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 4800,
    parameter int unsigned TIMEOUT_CYCLES = 720000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    // One counter serves both the inhibit phase and the timeout window; the
    // two never overlap in time.
    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] InhibitEnd  = CntW'(INHIBIT_CYCLES);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      frame_q, frame_d;
    logic            nack_q, nack_d;

    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    // Pin synchronizers; reset to the idle (high) line level so leaving reset
    // never looks like a falling edge.
    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            data_meta_q, data_sync_q;

    logic            clk_fall;
    logic            timeout;
    logic            fail;
    logic            final_try;

`ifdef PS2_TX_RETRY_EN
    logic            retried_q, retried_d;
    assign final_try = retried_q;
`else
    assign final_try = 1'b1;
`endif

    assign clk_fall = clk_prev_q & ~clk_sync_q;
    assign timeout  = (cnt_q == TimeoutLast);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retried_d = retried_q;
`endif

        case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (tx_valid && ready_q) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    state_d   = StInhibit;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    nack_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end

            StInhibit: begin
                cnt_d    = cnt_q + 1'b1;
                clk_oe_d = 1'b1;
                if (cnt_q == InhibitEnd) begin
                    // Release clock with data still low: request-to-send.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StReq;
                end else if (cnt_q == InhibitLast) begin
                    data_oe_d = 1'b1;
                end else begin
                    data_oe_d = 1'b0;
                end
            end

            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = StData;
                end
            end

            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    // Index 9 is the stop bit (1), which releases the line.
                    data_oe_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end

            StAck: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    nack_d  = data_sync_q;
                    if (data_sync_q && final_try) begin
                        err_d = 1'b1;
                    end
                    state_d = StWaitIdle;
                end
            end

            StWaitIdle: begin
                if (clk_sync_q && data_sync_q) begin
                    if (nack_q) begin
                        fail = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d   = StIdle;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // Error exit: release both lines and report, or restart once.
        if (fail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = StIdle;
`ifdef PS2_TX_RETRY_EN
            if (!retried_q) begin
                clk_oe_d  = 1'b1;
                done_d    = 1'b0;
                err_d     = 1'b0;
                nack_d    = 1'b0;
                cnt_d     = '0;
                retried_d = 1'b1;
                state_d   = StInhibit;
            end
`endif
        end

        // tx_ready stays low in the tx_done cycle so it rises one cycle later.
        ready_d = (state_d == StIdle) && !done_d;
        busy_d  = (state_d != StIdle);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            nack_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retried_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            nack_q      <= nack_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
`ifdef PS2_TX_RETRY_EN
            retried_q   <= retried_d;
`endif
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;

endmodule
